// File: rtl/updown_counter_presc.sv
// Up/down counter stepped by a prescaler tick.
// The counter stays within [0, MAX_VAL] and can either wrap or saturate at
// the bounds. It also supports synchronous clear, parallel load with clamping,
// and a one-cycle wrap event pulse.
module updown_counter_presc #(
    parameter int WIDTH     = 5,
    parameter int MAX_VAL   = 2**WIDTH-1,
    parameter int MAX_COUNT = 10_000_000,
    parameter int PRESC_W   = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             mode_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tick_o,
    output logic             wrap_o,
    output logic             max_o,
    output logic             min_o
);

    localparam logic [WIDTH-1:0]   MAX_V  = WIDTH'(MAX_VAL);
    localparam logic [PRESC_W-1:0] TERM_V = PRESC_W'(MAX_COUNT - 1);

    // Reject parameter sets the datapath cannot represent.
    generate
        if (WIDTH < 1 || MAX_VAL < 1 ||
            longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1) ||
            MAX_COUNT < 1 ||
            (longint'(1) << PRESC_W) < longint'(MAX_COUNT)) begin : g_param_check
            $error("updown_counter_presc: illegal parameter combination");
        end
    endgenerate

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               wrap_q, wrap_d;
    logic               term;
    logic [WIDTH-1:0]   load_clamped;

    // Next-state logic. Priority is clear, then load, then step.
    // A load still lets the prescaler run and the tick follow term,
    // but it suppresses the step in that cycle.
    always_comb begin
        presc_d      = presc_q;
        cnt_d        = cnt_q;
        tick_d       = 1'b0;
        wrap_d       = 1'b0;
        term         = en_i && (presc_q == TERM_V);
        load_clamped = (load_val_i > MAX_V) ? MAX_V : load_val_i;

        if (clear_i) begin
            presc_d = '0;
            cnt_d   = '0;
        end else begin
            if (en_i) begin
                presc_d = term ? '0 : presc_q + PRESC_W'(1);
            end
            tick_d = term;
            if (load_i) begin
                cnt_d = load_clamped;
            end else if (term) begin
                if (up_i) begin
                    if (cnt_q < MAX_V) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end else if (!mode_i) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end else if (!mode_i) begin
                        cnt_d  = MAX_V;
                        wrap_d = 1'b1;
                    end
                end
            end
        end
    end

    // State registers. An asynchronous reset restarts the whole prescaler period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign tick_o = tick_q;
    assign wrap_o = wrap_q;
    assign max_o  = (cnt_q == MAX_V);
    assign min_o  = (cnt_q == '0);

endmodule

// File: doc/updown_counter_presc.md
Name: updown_counter_presc

Overview:
- Parametrised successor to the existing fixed 5-bit up/down counter block.
- A prescaler generates a step tick every MAX_COUNT enabled clocks. On each tick a WIDTH-bit counter steps up or down within [0, MAX_VAL].
- Adds over the previous generation: runtime wrap/saturate mode, synchronous clear, parallel load, count enable, and a wrap event pulse.
- Instantiated under the TinyTapeout wrapper, driving the bidirectional pins.

Parameters:
- WIDTH, 5, counter width in bits.
- MAX_VAL, 2**WIDTH-1, upper count bound; legal range 1..2**WIDTH-1.
- MAX_COUNT, 10_000_000, clocks per step tick; must be >=1.
- PRESC_W, 24, prescaler width; must satisfy 2**PRESC_W >= MAX_COUNT.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  count enable; gates the prescaler.
- up_i  in  1  direction: 1 = up, 0 = down; sampled on the step edge.
- mode_i  in  1  0 = wrap at bounds, 1 = saturate at bounds.
- clear_i  in  1  synchronous clear of counter and prescaler.
- load_i  in  1  synchronous parallel load strobe.
- load_val_i  in  WIDTH  load value.
- cnt_o  out  WIDTH  registered count.
- tick_o  out  1  registered one-cycle step pulse.
- wrap_o  out  1  registered one-cycle pulse when a bound is crossed in wrap mode.
- max_o  out  1  cnt_o == MAX_VAL (combinational from register).
- min_o  out  1  cnt_o == 0 (combinational from register).

Behaviour:
- Reset (rst_ni=0, async, any time):
  - cnt=0, presc=0, tick_o=0, wrap_o=0.
  - Hence min_o=1, max_o=0.
  - Resuming from reset mid-operation restarts the full MAX_COUNT period.
- Prescaler:
  - If en_i=1: presc increments each clock. When presc==MAX_COUNT-1 ("term"), presc<=0 on that edge.
  - If en_i=0: presc holds, tick_o<=0.
  - MAX_COUNT=1: term is true every enabled clock.
- tick_o<=term. It rises on the same edge that cnt_o steps, so the first tick occurs MAX_COUNT enabled clocks after reset or clear.
- Priority per edge: clear_i > load_i > step.
- clear_i=1:
  - cnt<=0, presc<=0, tick_o<=0, wrap_o<=0.
  - Overrides load_i and term.
- load_i=1 (clear_i=0):
  - cnt<=min(load_val_i, MAX_VAL); out-of-range values are clamped to MAX_VAL.
  - The prescaler runs normally. tick_o still follows term, but no step is applied that cycle.
  - wrap_o<=0.
- Step, on term (no clear, no load):
  - up_i=1, cnt<MAX_VAL: cnt+1.
  - up_i=1, cnt==MAX_VAL: mode_i=0 gives cnt<=0 and wrap_o<=1; mode_i=1 holds at MAX_VAL with wrap_o<=0.
  - up_i=0, cnt>0: cnt-1.
  - up_i=0, cnt==0: mode_i=0 gives cnt<=MAX_VAL and wrap_o<=1; mode_i=1 holds at 0.
  - Arithmetic is unsigned. No intermediate value exceeds MAX_VAL or goes below 0. Counts in (MAX_VAL, 2**WIDTH-1] are unreachable.
- wrap_o is 0 on every edge without a wrapping step; it is a one-cycle pulse.
- up_i and mode_i changes take effect only at the next step edge; no internal latching between steps.
- Simultaneous en_i falling on a term cycle: term requires en_i=1 on that edge, so no step occurs.
- Out-of-range parameters are caught by an elaboration-time assertion; behaviour with illegal parameters is undefined.
- Gate budget: two registers (PRESC_W, WIDTH), two 1-bit output flops, comparators; no other state.

Test Plan:
(Use WIDTH=5, MAX_VAL=20, MAX_COUNT=4 unless stated.)
1. Reset then en_i=1, up_i=1, mode_i=0 for 12 clocks -> tick_o pulses on clocks 4, 8, 12; cnt_o goes 1, 2, 3; min_o=1 until the first tick. Assert rst_ni=0 asynchronously mid-period -> all outputs return to reset values immediately.
2. Load 20, up_i=1, mode_i=0 -> next tick: cnt_o=0, wrap_o=1 for exactly one cycle, max_o drops. Repeat with up_i=0 from 0 -> cnt_o=20, wrap_o=1, max_o=1.
3. mode_i=1, load 20, up_i=1 over 3 ticks -> cnt_o stays 20, wrap_o never asserts. Same with down from 0 -> holds at 0, min_o=1.
4. load_val_i=31 -> cnt_o=20 (clamped). Load 7 asserted on a term cycle -> cnt_o=7, tick_o=1, no step applied.
5. clear_i and load_i asserted together at presc=2 -> cnt_o=0, presc restarts, next tick_o exactly 4 enabled clocks later. en_i=0 for 10 clocks mid-period -> no ticks; the remaining period resumes.
6. MAX_COUNT=1, WIDTH=3, MAX_VAL=7, up_i toggling each clock -> cnt_o steps every clock following up_i. Random regression against a reference model covering all four mode/direction combinations.
